// File: rtl/md_unit_ctrl_pkg.sv
// Shared multiply/divide definitions: op encodings, controller state codes,
// default latencies and the HI/LO result payload.
package md_unit_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] md_mult  = 2'b00;
  localparam logic [1:0] md_multu = 2'b01;
  localparam logic [1:0] md_div   = 2'b10;
  localparam logic [1:0] md_divu  = 2'b11;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;
  localparam int unsigned DEF_CNT_W       = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage request/response bundle between the pipeline and the md controller.
interface md_unit_ctrl_if;
  import md_unit_ctrl_pkg::*;

  logic            start;
  logic [1:0]      mdop;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            mthi;
  logic            mtlo;
  logic            rd_hi;
  logic            usemd_d;
  logic [XLEN-1:0] mdout;
  logic            busy;
  logic            stall;

  modport master (
    output start, mdop, a, b, mthi, mtlo, rd_hi, usemd_d,
    input  mdout, busy, stall
  );

  modport slave (
    input  start, mdop, a, b, mthi, mtlo, rd_hi, usemd_d,
    output mdout, busy, stall
  );

endinterface

// File: rtl/md_unit_ctrl_arith.sv
// Combinational 32x32 multiply / divide producing the HI/LO pair,
// including divide-by-zero and signed-overflow results.
module md_unit_ctrl_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [1:0]      mdop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output md_result_t      res_c
);

  logic signed [2*XLEN-1:0] prod_s;
  logic        [2*XLEN-1:0] prod_u;
  logic        [XLEN-1:0]   b_safe;
  logic signed [XLEN-1:0]   quo_s;
  logic signed [XLEN-1:0]   rem_s;
  logic        [XLEN-1:0]   quo_u;
  logic        [XLEN-1:0]   rem_u;
  logic                     div_zero;
  logic                     div_ovf;

  assign prod_s = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
  assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Special cases are muxed in below; keep the divider on a harmless divisor.
  assign b_safe = (div_zero || div_ovf) ? XLEN'(1) : b;

  assign quo_s = $signed(a) / $signed(b_safe);
  assign rem_s = $signed(a) % $signed(b_safe);
  assign quo_u = a / b_safe;
  assign rem_u = a % b_safe;

  always_comb begin
    res_c = '0;
    case (mdop)
      md_mult: begin
        res_c.hi = prod_s[2*XLEN-1:XLEN];
        res_c.lo = prod_s[XLEN-1:0];
      end
      md_multu: begin
        res_c.hi = prod_u[2*XLEN-1:XLEN];
        res_c.lo = prod_u[XLEN-1:0];
      end
      md_div: begin
        if (div_zero) begin
          res_c.hi = a;
          res_c.lo = '1;
        end else if (div_ovf) begin
          res_c.hi = '0;
          res_c.lo = a;
        end else begin
          res_c.hi = rem_s;
          res_c.lo = quo_s;
        end
      end
      md_divu: begin
        if (div_zero) begin
          res_c.hi = a;
          res_c.lo = '1;
        end else begin
          res_c.hi = rem_u;
          res_c.lo = quo_u;
        end
      end
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy window, architectural HI/LO,
// mthi/mtlo writes, mfhi/mflo read mux and the D-stage stall request.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  md_unit_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state;
  md_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  pend_hi;
  logic [XLEN-1:0]  pend_lo;
  md_result_t       arith_res;
  logic             load;
  logic             commit;
  logic             hi_we;
  logic             lo_we;
  logic             in_busy;

  md_unit_ctrl_arith u_arith (
    .mdop  (bus.mdop),
    .a     (bus.a),
    .b     (bus.b),
    .res_c (arith_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (bus.start)      state_nxt = MD_BUSY;
      MD_BUSY: if (cnt == CNT_ONE) state_nxt = MD_IDLE;
      default:                     state_nxt = MD_IDLE;
    endcase
  end

  // Start has priority over mt writes; nothing is accepted while busy.
  always_comb begin
    in_busy   = (state == MD_BUSY);
    load      = (state == MD_IDLE) && bus.start;
    commit    = in_busy && (cnt == CNT_ONE);
    hi_we     = (state == MD_IDLE) && !bus.start && bus.mthi;
    lo_we     = (state == MD_IDLE) && !bus.start && bus.mtlo;
    bus.busy  = in_busy;
    bus.stall = bus.usemd_d && (in_busy || bus.start);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      if (load) begin
        pend_hi <= arith_res.hi;
        pend_lo <= arith_res.lo;
        cnt     <= bus.mdop[1] ? DIV_LOAD : MULT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (hi_we) hi <= bus.a;
      if (lo_we) lo <= bus.a;
    end
  end

  assign bus.mdout = bus.rd_hi ? hi : lo;

endmodule
